// File: rtl/ocp_pkg.sv
// Shared types and widths for the OCP slave memory endpoint.
// Contents: command/response encodings, bus widths and the responder
// state enum. No ports; imported by the interface and all modules.
package ocp_pkg;

   localparam int OCP_DW  = 32;
   localparam int OCP_TW  = 4;
   localparam int OCP_BLW = 4;

   typedef enum logic [2:0] {
      CMD_IDLE = 3'd0,
      CMD_WR   = 3'd1,
      CMD_RD   = 3'd2
   } ocp_cmd_e;

   typedef enum logic [1:0] {
      RESP_NULL = 2'd0,
      RESP_DVA  = 2'd1,
      RESP_FAIL = 2'd2,
      RESP_ERR  = 2'd3
   } ocp_resp_e;

   typedef enum logic [1:0] {
      S_IDLE,
      S_WR_DATA,
      S_WR_RESP,
      S_RD_RESP
   } ocp_slv_state_e;

endpackage

// File: rtl/ocp_slave_mem_if.sv
// OCP master/slave signal bundle.
// Master drives: MCmd, MAddr, MBurstLength, MTagID, MDataValid, MData,
//                MDataLast, MRespAccept.
// Slave drives:  SCmdAccept, SDataAccept, SData, SResp, SRespLast, STagID.
interface ocp_slave_mem_if #(
   parameter int AW = 32
) ();
   import ocp_pkg::*;

   logic [2:0]         MCmd;
   logic [AW-1:0]      MAddr;
   logic [OCP_BLW-1:0] MBurstLength;
   logic [OCP_TW-1:0]  MTagID;
   logic               MDataValid;
   logic [OCP_DW-1:0]  MData;
   logic               MDataLast;
   logic               MRespAccept;
   logic               SCmdAccept;
   logic               SDataAccept;
   logic [OCP_DW-1:0]  SData;
   logic [1:0]         SResp;
   logic               SRespLast;
   logic [OCP_TW-1:0]  STagID;

   modport master (
      output MCmd, MAddr, MBurstLength, MTagID, MDataValid, MData, MDataLast, MRespAccept,
      input  SCmdAccept, SDataAccept, SData, SResp, SRespLast, STagID
   );

   modport slave (
      input  MCmd, MAddr, MBurstLength, MTagID, MDataValid, MData, MDataLast, MRespAccept,
      output SCmdAccept, SDataAccept, SData, SResp, SRespLast, STagID
   );

endinterface

// File: rtl/ocp_slave_ram.sv
// Word memory for the OCP slave: DEPTH x 32, one synchronous write port,
// one combinational read port. Contents are not reset.
// Ports: clk, we/waddr/wdata (write), raddr/rdata (read).
module ocp_slave_ram
   import ocp_pkg::*;
#(
   parameter int DEPTH = 256
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [OCP_DW-1:0]        wdata,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [OCP_DW-1:0]        rdata
);

   logic [OCP_DW-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/ocp_slave_mem.sv
// OCP slave responder backed by a word memory. Accepts one WR or RD burst
// at a time, stores write beats, returns read beats and write responses.
// Ports: clk, rst (async, active-low), bus (ocp_slave_mem_if.slave).
//
// state     | meaning
// S_IDLE    | ready for a command, SCmdAccept high
// S_WR_DATA | consuming write beats, SDataAccept high
// S_WR_RESP | write response presented until MRespAccept
// S_RD_RESP | read beats presented, one per accepted cycle
module ocp_slave_mem
   import ocp_pkg::*;
#(
   parameter int DEPTH = 256,
   parameter int AW    = 32
) (
   input  logic              clk,
   input  logic              rst,
   ocp_slave_mem_if.slave    bus
);

   localparam int IW = $clog2(DEPTH);

   ocp_slv_state_e state, state_nxt;

   // idx carries one extra bit; once it reaches DEPTH it stays there so the
   // burst remains out of range instead of wrapping.
   logic [IW:0]         idx;
   logic [OCP_BLW-1:0]  cnt;
   logic [OCP_TW-1:0]   tag;
   logic                err;

   logic                cmd_wr, cmd_rd, cmd_err;
   logic [IW:0]         cmd_idx, idx_inc;
   logic [OCP_BLW-1:0]  cmd_len;
   logic                cur_oor, cnt_last;
   logic                wr_beat, wr_end, wr_err_nxt, rd_beat_err;
   logic [OCP_DW-1:0]   rdata;

   assign cmd_wr  = (bus.MCmd == CMD_WR);
   assign cmd_rd  = (bus.MCmd == CMD_RD);
   assign cmd_idx = {1'b0, bus.MAddr[2 +: IW]};
   assign cmd_len = (bus.MBurstLength == '0) ? OCP_BLW'(1) : bus.MBurstLength;
   assign cmd_err = (bus.MAddr[1:0] != 2'b00) | (|bus.MAddr[AW-1:2+IW])
                    | (bus.MBurstLength == '0);

   assign cur_oor  = idx[IW];
   assign idx_inc  = cur_oor ? idx : idx + 1'b1;
   assign cnt_last = (cnt == OCP_BLW'(1));

   assign wr_beat    = (state == S_WR_DATA) && bus.MDataValid;
   assign wr_end     = wr_beat && (bus.MDataLast || cnt_last);
   assign wr_err_nxt = err | cur_oor | (bus.MDataLast != cnt_last);
   assign rd_beat_err = err | cur_oor;

   assign bus.SCmdAccept  = (state == S_IDLE) && rst;
   assign bus.SDataAccept = (state == S_WR_DATA);

   ocp_slave_ram #(.DEPTH(DEPTH)) u_ram (
      .clk   (clk),
      .we    (wr_beat && !err && !cur_oor),
      .waddr (idx[IW-1:0]),
      .wdata (bus.MData),
      .raddr ((state == S_IDLE) ? cmd_idx[IW-1:0] : idx[IW-1:0]),
      .rdata (rdata)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (cmd_wr)      state_nxt = S_WR_DATA;
            else if (cmd_rd) state_nxt = S_RD_RESP;
         end
         S_WR_DATA: if (wr_end) state_nxt = S_WR_RESP;
         S_WR_RESP: if (bus.MRespAccept) state_nxt = S_IDLE;
         S_RD_RESP: if (bus.MRespAccept && bus.SRespLast) state_nxt = S_IDLE;
         default:   state_nxt = S_IDLE;
      endcase
   end

   // For writes idx points at the beat being consumed; for reads it points
   // at the beat after the one currently presented on SData.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         idx           <= '0;
         cnt           <= '0;
         tag           <= '0;
         err           <= 1'b0;
         bus.SData     <= '0;
         bus.SResp     <= RESP_NULL;
         bus.SRespLast <= 1'b0;
         bus.STagID    <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (cmd_wr) begin
                  idx <= cmd_idx;
                  cnt <= cmd_len;
                  tag <= bus.MTagID;
                  err <= cmd_err;
               end else if (cmd_rd) begin
                  idx           <= cmd_idx + 1'b1;
                  cnt           <= cmd_len - 1'b1;
                  tag           <= bus.MTagID;
                  err           <= cmd_err;
                  bus.SData     <= cmd_err ? '0 : rdata;
                  bus.SResp     <= cmd_err ? RESP_ERR : RESP_DVA;
                  bus.SRespLast <= (cmd_len == OCP_BLW'(1));
                  bus.STagID    <= bus.MTagID;
               end
            end
            S_WR_DATA: begin
               if (wr_beat) begin
                  idx <= idx_inc;
                  cnt <= cnt - 1'b1;
                  if (wr_end) begin
                     err           <= wr_err_nxt;
                     bus.SData     <= '0;
                     bus.SResp     <= wr_err_nxt ? RESP_ERR : RESP_DVA;
                     bus.SRespLast <= 1'b1;
                     bus.STagID    <= tag;
                  end else begin
                     err <= err | cur_oor;
                  end
               end
            end
            S_WR_RESP: begin
               if (bus.MRespAccept) begin
                  bus.SResp     <= RESP_NULL;
                  bus.SRespLast <= 1'b0;
               end
            end
            S_RD_RESP: begin
               if (bus.MRespAccept) begin
                  if (bus.SRespLast) begin
                     bus.SData     <= '0;
                     bus.SResp     <= RESP_NULL;
                     bus.SRespLast <= 1'b0;
                  end else begin
                     idx           <= idx_inc;
                     cnt           <= cnt - 1'b1;
                     err           <= rd_beat_err;
                     bus.SData     <= rd_beat_err ? '0 : rdata;
                     bus.SResp     <= rd_beat_err ? RESP_ERR : RESP_DVA;
                     bus.SRespLast <= cnt_last;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ocp_slave_mem.sv
// Self-checking bench for ocp_slave_mem: expected response beats are queued
// when commands are driven and compared as the DUT hands them over.
module tb_ocp_slave_mem;
   import ocp_pkg::*;

   localparam int DEPTH = 256;

   logic clk = 1'b0;
   logic rst = 1'b1;

   ocp_slave_mem_if #(.AW(32)) bus ();

   ocp_slave_mem #(.DEPTH(DEPTH), .AW(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] data;
      logic [1:0]  resp;
      logic        last;
      logic [3:0]  tag;
      bit          chk_data;
   } exp_t;

   exp_t        sbq[$];
   logic [31:0] model[int];
   logic [31:0] wdat[16];
   int          n_chk  = 0;
   int          n_fail = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // Response monitor: a beat is consumed when presented with MRespAccept high.
   exp_t e;
   always @(negedge clk) begin
      if (rst && bus.SResp != RESP_NULL && bus.MRespAccept) begin
         if (sbq.size() == 0) begin
            chk("rsp_unexpected", {30'b0, bus.SResp}, {30'b0, RESP_NULL});
         end else begin
            e = sbq.pop_front();
            chk("rsp_code", {30'b0, bus.SResp}, {30'b0, e.resp});
            chk("rsp_last", {31'b0, bus.SRespLast}, {31'b0, e.last});
            chk("rsp_tag", {28'b0, bus.STagID}, {28'b0, e.tag});
            if (e.chk_data) chk("rsp_data", bus.SData, e.data);
         end
      end
   end

   task automatic send_cmd(input logic [2:0] cmd, input logic [31:0] addr,
                           input int len, input logic [3:0] tag);
      bit ok = 0;
      bus.MCmd         = cmd;
      bus.MAddr        = addr;
      bus.MBurstLength = 4'(len);
      bus.MTagID       = tag;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.SCmdAccept) begin ok = 1; break; end
      end
      if (!ok) chk("cmd_accept_timeout", {31'b0, bus.SCmdAccept}, 32'd1);
      @(posedge clk); #1;
      bus.MCmd = CMD_IDLE;
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 50; i++) begin
         if (sbq.size() == 0) break;
         @(posedge clk); #1;
      end
      chk("drain", sbq.size(), 32'd0);
   endtask

   task automatic push_rd_exp(input logic [31:0] addr, input int len, input logic [3:0] tag);
      bit aerr = (addr[1:0] != 2'b00) || (addr[31:10] != 0);
      int base = int'(addr[9:2]);
      for (int b = 0; b < len; b++) begin
         int w  = base + b;
         bit be = aerr || (w >= DEPTH);
         sbq.push_back('{data: be ? 32'h0 : model[w],
                         resp: be ? RESP_ERR : RESP_DVA,
                         last: (b == len - 1), tag: tag, chk_data: 1'b1});
      end
   endtask

   task automatic wr_burst(input logic [31:0] addr, input int lenf, input int nbeats,
                           input logic [3:0] tag, input logic [1:0] exp_resp,
                           input bit gap, input bit drain);
      bit ok;
      sbq.push_back('{data: 32'h0, resp: exp_resp, last: 1'b1, tag: tag, chk_data: 1'b0});
      send_cmd(CMD_WR, addr, lenf, tag);
      for (int b = 0; b < nbeats; b++) begin
         if (gap && (b % 2 == 1)) begin
            bus.MDataValid = 1'b0;
            @(posedge clk); #1;
         end
         bus.MDataValid = 1'b1;
         bus.MData      = wdat[b];
         bus.MDataLast  = (b == nbeats - 1);
         ok = 0;
         for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.SDataAccept) begin ok = 1; break; end
         end
         if (!ok) chk("data_accept_timeout", {31'b0, bus.SDataAccept}, 32'd1);
         @(posedge clk); #1;
         bus.MDataValid = 1'b0;
         bus.MDataLast  = 1'b0;
      end
      if (exp_resp == RESP_DVA)
         for (int b = 0; b < nbeats; b++) model[int'(addr[9:2]) + b] = wdat[b];
      if (drain) wait_drain();
   endtask

   task automatic rd_burst(input logic [31:0] addr, input int len, input logic [3:0] tag,
                           input int stall_beat, input int stall_cyc);
      int cyc = 0;
      int left = stall_cyc;
      int vis;
      bit stalled;
      push_rd_exp(addr, len, tag);
      send_cmd(CMD_RD, addr, len, tag);
      for (int i = 0; i < 100; i++) begin
         if (sbq.size() == 0) break;
         vis = len - sbq.size() + 1;
         stalled = (vis == stall_beat) && (left > 0);
         bus.MRespAccept = !stalled;
         if (stalled) left--;
         @(posedge clk); #1;
         cyc++;
         if (stalled) begin
            chk("stall_data", bus.SData, sbq[0].data);
            chk("stall_resp", {30'b0, bus.SResp}, {30'b0, sbq[0].resp});
            chk("stall_tag", {28'b0, bus.STagID}, {28'b0, sbq[0].tag});
         end
      end
      chk("rd_cycles", cyc, len + stall_cyc);
      bus.MRespAccept = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.MCmd = CMD_IDLE; bus.MAddr = '0; bus.MBurstLength = '0; bus.MTagID = '0;
      bus.MDataValid = 1'b0; bus.MData = '0; bus.MDataLast = 1'b0; bus.MRespAccept = 1'b1;

      #3 rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_sdata", bus.SData, 32'h0);
      chk("rst_sresp", {30'b0, bus.SResp}, 32'd0);
      chk("rst_slast", {31'b0, bus.SRespLast}, 32'd0);
      chk("rst_stag", {28'b0, bus.STagID}, 32'd0);
      chk("rst_cmdacc", {31'b0, bus.SCmdAccept}, 32'd0);
      chk("rst_dataacc", {31'b0, bus.SDataAccept}, 32'd0);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("idle_cmdacc", {31'b0, bus.SCmdAccept}, 32'd1);

      // single beat write then read
      wdat[0] = 32'hDEADBEEF;
      wr_burst(32'h10, 1, 1, 4'd3, RESP_DVA, 1'b0, 1'b1);
      rd_burst(32'h10, 1, 4'd5, 0, 0);

      // 4-beat burst, gapped write data, back-to-back read
      for (int i = 0; i < 4; i++) wdat[i] = 32'(i + 1);
      wr_burst(32'h20, 4, 4, 4'd1, RESP_DVA, 1'b1, 1'b1);
      rd_burst(32'h20, 4, 4'd2, 0, 0);

      // read backpressure on beat 2
      rd_burst(32'h20, 3, 4'd6, 2, 2);

      // misaligned write leaves memory unchanged
      wdat[0] = 32'hA5A5A5A5;
      wr_burst(32'h0, 1, 1, 4'd4, RESP_DVA, 1'b0, 1'b1);
      wdat[0] = 32'h12345678;
      wr_burst(32'h2, 1, 1, 4'd7, RESP_ERR, 1'b0, 1'b1);
      rd_burst(32'h0, 1, 4'd7, 0, 0);

      // burst running off the end of memory
      wdat[0] = 32'h111; wdat[1] = 32'h222;
      wr_burst(32'h3F8, 2, 2, 4'd2, RESP_DVA, 1'b0, 1'b1);
      rd_burst(32'h3F8, 4, 4'd3, 0, 0);

      // early MDataLast, zero length, address above memory
      wdat[0] = 32'h55; wdat[1] = 32'h66;
      wr_burst(32'h80, 4, 2, 4'd5, RESP_ERR, 1'b0, 1'b1);
      wr_burst(32'h84, 0, 1, 4'd6, RESP_ERR, 1'b0, 1'b1);
      rd_burst(32'h400, 1, 4'd1, 0, 0);

      // reserved command is ignored
      bus.MCmd = 3'd5;
      repeat (3) begin
         @(negedge clk);
         chk("rsvd_cmdacc", {31'b0, bus.SCmdAccept}, 32'd1);
         chk("rsvd_sresp", {30'b0, bus.SResp}, 32'd0);
      end
      @(posedge clk); #1;
      bus.MCmd = CMD_IDLE;

      // command gating during a stalled write response
      wdat[0] = 32'hCAFEF00D;
      bus.MRespAccept = 1'b0;
      wr_burst(32'h10, 1, 1, 4'd8, RESP_DVA, 1'b0, 1'b0);
      push_rd_exp(32'h10, 1, 4'd9);
      bus.MCmd = CMD_RD; bus.MAddr = 32'h10; bus.MBurstLength = 4'd1; bus.MTagID = 4'd9;
      repeat (3) begin
         @(negedge clk);
         chk("gate_cmdacc", {31'b0, bus.SCmdAccept}, 32'd0);
         chk("gate_wr_resp", {30'b0, bus.SResp}, {30'b0, RESP_DVA});
      end
      @(posedge clk); #1;
      bus.MRespAccept = 1'b1;
      @(negedge clk);
      chk("gate_cmdacc_accepting", {31'b0, bus.SCmdAccept}, 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("gate_cmdacc_idle", {31'b0, bus.SCmdAccept}, 32'd1);
      @(posedge clk); #1;
      bus.MCmd = CMD_IDLE;
      wait_drain();

      // reset in the middle of a read burst
      push_rd_exp(32'h20, 3, 4'hA);
      send_cmd(CMD_RD, 32'h20, 3, 4'hA);
      bus.MRespAccept = 1'b1;
      @(posedge clk); #1;
      chk("mid_beat2_data", bus.SData, 32'd2);
      rst = 1'b0;
      #1;
      chk("mid_rst_sdata", bus.SData, 32'h0);
      chk("mid_rst_sresp", {30'b0, bus.SResp}, 32'd0);
      chk("mid_rst_slast", {31'b0, bus.SRespLast}, 32'd0);
      chk("mid_rst_stag", {28'b0, bus.STagID}, 32'd0);
      chk("mid_rst_cmdacc", {31'b0, bus.SCmdAccept}, 32'd0);
      sbq.delete();
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rd_burst(32'h20, 4, 4'hB, 0, 0);
      rd_burst(32'h10, 1, 4'hC, 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
